// File: rtl/cfg_types_pkg.sv
// Shared types for the accelerator memory path: response owner and SRAM request bundle.
package cfg_types_pkg;

    localparam int unsigned CFG_ADDR_W = 10;
    localparam int unsigned CFG_DATA_W = 32;

    // Bit positions of the one-hot grant vector produced by rr_arb2
    localparam int unsigned GNT_HOST = 0;
    localparam int unsigned GNT_ACC  = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_ACC  = 2'd2
    } owner_t;

    typedef struct packed {
        logic                      en;
        logic [CFG_ADDR_W-1:0]     addr;
        logic                      we;
        logic [CFG_DATA_W/8-1:0]   be;
        logic [CFG_DATA_W-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (host vs accelerator) with accelerator burst lock
// bounded by a fairness counter. Grant is combinational and one-hot.
module rr_arb2
    import cfg_types_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_host_req,
    input  logic       i_acc_req,
    input  logic       i_acc_lock,
    output logic [1:0] o_gnt,
    output logic       o_starve
);

    localparam logic [7:0] LockMax = 8'(MAX_LOCK);

    logic       r_last_acc;
    logic [7:0] r_lock_cnt;
    logic       w_host_req;
    logic       w_acc_req;
    logic       w_lock_full;

    // Requests are masked while in reset so every output reads as zero
    assign w_host_req  = i_host_req & rst_n;
    assign w_acc_req   = i_acc_req & rst_n;
    assign w_lock_full = (r_lock_cnt >= LockMax);

    always_comb begin
        o_gnt    = '0;
        o_starve = 1'b0;
        if (w_host_req && w_acc_req) begin
            if (i_acc_lock) begin
                if (w_lock_full) begin
                    o_gnt[GNT_HOST] = 1'b1;
                    o_starve        = 1'b1;
                end else begin
                    o_gnt[GNT_ACC] = 1'b1;
                end
            end else if (r_last_acc) begin
                o_gnt[GNT_HOST] = 1'b1;
            end else begin
                o_gnt[GNT_ACC] = 1'b1;
            end
        end else if (w_host_req) begin
            o_gnt[GNT_HOST] = 1'b1;
        end else if (w_acc_req) begin
            o_gnt[GNT_ACC] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_acc <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            if (o_gnt[GNT_ACC]) begin
                r_last_acc <= 1'b1;
            end else if (o_gnt[GNT_HOST]) begin
                r_last_acc <= 1'b0;
            end

            if (o_gnt[GNT_HOST] || !i_acc_lock) begin
                r_lock_cnt <= '0;
            end else if (o_gnt[GNT_ACC] && i_host_req && !w_lock_full) begin
                r_lock_cnt <= r_lock_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/accel_mem_arbiter.sv
// Shares the single-port data SRAM between host and accelerator; muxes the granted
// request onto the SRAM and routes the one-cycle-latency response back to its owner.
module accel_mem_arbiter
    import cfg_types_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CFG_ADDR_W,
    parameter int unsigned DATA_WIDTH = CFG_DATA_W,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    host_req,
    input  logic [ADDR_WIDTH-1:0]   host_addr,
    input  logic                    host_we,
    input  logic [DATA_WIDTH/8-1:0] host_be,
    input  logic [DATA_WIDTH-1:0]   host_wdata,
    output logic                    host_gnt,
    output logic                    host_rvalid,
    output logic [DATA_WIDTH-1:0]   host_rdata,
    input  logic                    acc_req,
    input  logic [ADDR_WIDTH-1:0]   acc_addr,
    input  logic                    acc_we,
    input  logic [DATA_WIDTH/8-1:0] acc_be,
    input  logic [DATA_WIDTH-1:0]   acc_wdata,
    input  logic                    acc_lock,
    output logic                    acc_gnt,
    output logic                    acc_rvalid,
    output logic [DATA_WIDTH-1:0]   acc_rdata,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    lock_starve_o
);

    logic [1:0]            w_gnt;
    owner_t                r_resp_owner;
    logic                  r_resp_we;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic [DATA_WIDTH-1:0] r_acc_rdata;

    rr_arb2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_rr_arb2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_host_req (host_req),
        .i_acc_req  (acc_req),
        .i_acc_lock (acc_lock),
        .o_gnt      (w_gnt),
        .o_starve   (lock_starve_o)
    );

    assign host_gnt = w_gnt[GNT_HOST];
    assign acc_gnt  = w_gnt[GNT_ACC];
    assign mem_en   = host_gnt | acc_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (acc_gnt) begin
            mem_addr  = acc_addr;
            mem_we    = acc_we;
            mem_be    = acc_be;
            mem_wdata = acc_wdata;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_be    = host_be;
            mem_wdata = host_wdata;
        end
    end

    // Response owner FSM; the hold registers capture read data so rdata stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_owner <= OWN_NONE;
            r_resp_we    <= 1'b0;
            r_host_rdata <= '0;
            r_acc_rdata  <= '0;
        end else begin
            if (acc_gnt) begin
                r_resp_owner <= OWN_ACC;
            end else if (host_gnt) begin
                r_resp_owner <= OWN_HOST;
            end else begin
                r_resp_owner <= OWN_NONE;
            end
            r_resp_we <= mem_we;
            if (r_resp_owner == OWN_HOST && !r_resp_we) begin
                r_host_rdata <= mem_rdata;
            end
            if (r_resp_owner == OWN_ACC && !r_resp_we) begin
                r_acc_rdata <= mem_rdata;
            end
        end
    end

    assign host_rvalid = (r_resp_owner == OWN_HOST);
    assign acc_rvalid  = (r_resp_owner == OWN_ACC);
    assign host_rdata  = (host_rvalid && !r_resp_we) ? mem_rdata : r_host_rdata;
    assign acc_rdata   = (acc_rvalid && !r_resp_we) ? mem_rdata : r_acc_rdata;

endmodule
